// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: ALU passthrough to MEM/WB, req/ack data-memory port for loads/stores.
// Optional bounded wait for memAck enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exRegWrEn,
  input  logic [1:0]        exMulSel,
  input  logic [31:0]       exAluOut,
  input  logic [31:0]       exData2Out,
  input  logic [31:0]       exPC,
  input  logic              exIsLoad,
  input  logic              exIsStore,
  output logic              stall,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memRdata,
  output logic              wbRegWrEn,
  output logic [1:0]        wbMulSel,
  output logic [31:0]       wbData,
  output logic [31:0]       wbPC,
  output logic              wbIsLoad,
  output logic              misalignErr,
  output logic              timeoutErr
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nxt;
  logic   mem_op;
  logic   misalign;
  logic   timeout;

  assign mem_op   = exIsLoad | exIsStore;
  assign misalign = mem_op && (exAluOut[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] wait_cnt;

  // Held at zero in IDLE, so it is already clear on entry to BUSY.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE)
      wait_cnt <= '0;
    else if (!memAck)
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == BUSY) && !memAck && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !misalign) begin
          stall     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (memAck || timeout)
          state_nxt = IDLE;
        else
          stall = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      memReq      <= 1'b0;
      memWe       <= 1'b0;
      memAddr     <= '0;
      memWdata    <= '0;
      wbRegWrEn   <= 1'b0;
      wbMulSel    <= '0;
      wbData      <= '0;
      wbPC        <= '0;
      wbIsLoad    <= 1'b0;
      misalignErr <= 1'b0;
      timeoutErr  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (!mem_op) begin
            wbRegWrEn <= exRegWrEn;
            wbMulSel  <= exMulSel;
            wbData    <= exAluOut;
            wbPC      <= exPC;
            wbIsLoad  <= 1'b0;
          end else if (misalign) begin
            wbRegWrEn   <= 1'b0;
            wbPC        <= exPC;
            misalignErr <= 1'b1;
          end else begin
            memReq    <= 1'b1;
            memWe     <= exIsStore & ~exIsLoad;
            memAddr   <= exAluOut[ADDR_W-1:0];
            memWdata  <= DATA_W'(exData2Out);
            wbRegWrEn <= 1'b0;
          end
        end
        BUSY: begin
          if (memAck) begin
            memReq    <= 1'b0;
            wbRegWrEn <= exRegWrEn & exIsLoad;
            wbMulSel  <= exMulSel;
            wbPC      <= exPC;
            wbData    <= exIsLoad ? 32'(memRdata) : exAluOut;
            wbIsLoad  <= exIsLoad;
          end else begin
            wbRegWrEn <= 1'b0;
            if (timeout) begin
              memReq     <= 1'b0;
              timeoutErr <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
